// File: rtl/rr_arbiter_4req.sv
// Round-robin arbiter sharing one encoded resource between four requesters.
// A requester keeps its req bit high for as long as it owns the resource; the
// grant is registered, one-hot, and accompanied by its 2-bit binary index.
// After every release, priority rotates to the requester after the last owner.
// Successive grants are always separated by at least one idle cycle.
//
// Optional feature, enabled by defining ARB_TIMEOUT_EN:
//   A hold counter bounds how long an owner may keep the grant while another
//   requester is waiting. The grant is revoked after HOLD_MAX cycles, and
//   preempt pulses for one cycle. Without the macro, preempt is tied to 0.
module rr_arbiter_4req #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_idx,
    output logic            gnt_valid,
    output logic            preempt
);

    // The index width and the rotation arithmetic assume exactly four requesters.
    if (NREQ != 4) begin : g_bad_nreq
        $error("rr_arbiter_4req supports NREQ == 4 only");
    end
    if (HOLD_MAX < 2) begin : g_bad_hold
        $error("rr_arbiter_4req requires HOLD_MAX >= 2");
    end

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [1:0]      r_ptr;
    logic [1:0]      w_ptr_next;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_gnt_next;
    logic [1:0]      r_gnt_idx;
    logic [1:0]      w_gnt_idx_next;
    logic            r_gnt_valid;
    logic            w_gnt_valid_next;

    logic            w_pick_valid;
    logic [1:0]      w_pick_idx;
    logic            w_owner_req;
    logic            w_others_req;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HoldW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_MAX - 1);

    logic [HoldW-1:0] r_hold;
    logic [HoldW-1:0] w_hold_next;
    logic             r_preempt;
    logic             w_preempt_next;
`endif

    // Rotating search: the first requester at or after r_ptr (mod 4) wins.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        logic [1:0] cand;
        w_pick_valid = 1'b0;
        w_pick_idx   = r_ptr;
        cand         = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = r_ptr + 2'(k);
            if (req[cand]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = cand;
            end
        end
    end

    // Owner's own request, and whether anyone else is waiting for the resource.
    always_comb begin
        w_owner_req  = req[r_gnt_idx];
        w_others_req = |(req & ~r_gnt);
    end

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_gnt_next       = r_gnt;
        w_gnt_idx_next   = r_gnt_idx;
        w_gnt_valid_next = r_gnt_valid;
`ifdef ARB_TIMEOUT_EN
        w_hold_next      = r_hold;
        w_preempt_next   = 1'b0;
`endif

        unique case (r_state)
            StIdle: begin
                // The pointer only moves on release/preempt, never here.
                if (w_pick_valid) begin
                    w_state_next     = StGrant;
                    w_gnt_next       = NREQ'(1) << w_pick_idx;
                    w_gnt_idx_next   = w_pick_idx;
                    w_gnt_valid_next = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    w_hold_next      = '0;
`endif
                end
            end

            StGrant: begin
                if (!w_owner_req) begin
                    // Release: always pass through IDLE before the next grant.
                    w_state_next     = StIdle;
                    w_gnt_next       = '0;
                    w_gnt_idx_next   = 2'd0;
                    w_gnt_valid_next = 1'b0;
                    w_ptr_next       = r_gnt_idx + 2'd1;
`ifdef ARB_TIMEOUT_EN
                end else if (r_hold == HoldLast && w_others_req) begin
                    // Forced rotation: owner has used its full slot and
                    // someone else is waiting.
                    w_state_next     = StIdle;
                    w_gnt_next       = '0;
                    w_gnt_idx_next   = 2'd0;
                    w_gnt_valid_next = 1'b0;
                    w_ptr_next       = r_gnt_idx + 2'd1;
                    w_preempt_next   = 1'b1;
                end else if (r_hold != HoldLast) begin
                    // Saturate at HoldLast so a lone owner keeps the grant.
                    w_hold_next      = r_hold + HoldW'(1);
`endif
                end
            end

            default: begin
                w_state_next     = StIdle;
                w_gnt_next       = '0;
                w_gnt_idx_next   = 2'd0;
                w_gnt_valid_next = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_ptr       <= 2'd0;
            r_gnt       <= '0;
            r_gnt_idx   <= 2'd0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_gnt       <= w_gnt_next;
            r_gnt_idx   <= w_gnt_idx_next;
            r_gnt_valid <= w_gnt_valid_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and the one-cycle preempt pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold    <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_hold    <= w_hold_next;
            r_preempt <= w_preempt_next;
        end
    end

    assign preempt = r_preempt;
`else
    assign preempt = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter_4req.sv
// Self-checking bench for rr_arbiter_4req: directed scenarios plus randomized
// request traffic compared against a behavioural owner/pointer model.
module tb_rr_arbiter_4req;

    localparam int HOLD_MAX = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int checks;
    int failures;

    // Reference model: current owner (-1 = none), rotating pointer, cycles held.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_pre;

    rr_arbiter_4req #(
        .NREQ    (4),
        .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {gnt, gnt_idx, gnt_valid, preempt} from the model state.
    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        logic [1:0] ix;
        g  = 4'b0000;
        ix = 2'd0;
        if (m_owner >= 0) begin
            g  = 4'b0001 << m_owner;
            ix = 2'(m_owner);
        end
        return {g, ix, (m_owner >= 0), m_pre};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_pre   = 1'b0;
    endtask

    // Advance the model by one clock given the requests sampled at that edge.
    task automatic model_step(input logic [3:0] r);
        m_pre = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_hold  = 0;
                end
            end
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (m_hold == HOLD_MAX - 1 && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_pre   = 1'b1;
            end else if (m_hold < HOLD_MAX - 1) begin
                m_hold++;
            end
`endif
        end
    endtask

    // Drive requests, clock once, and leave time at edge+1 for sampling.
    task automatic tick(input logic [3:0] r);
        req = r;
        model_step(r);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #3;
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({gnt, gnt_idx, gnt_valid, preempt} !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: got %b required %b", {gnt, gnt_idx, gnt_valid, preempt},
                     8'h00);
        end
        tick(4'b1111);
        tick(4'b1111);
        // Reset mid-grant, mid-cycle: outputs must clear with no clock edge.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt, gnt_idx, gnt_valid} !== 7'h00) begin
            failures++;
            $display("FAIL reset_async: got %b required %b", {gnt, gnt_idx, gnt_valid}, 7'h00);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        tick(4'b1111);
        checks++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant: got gnt=%b idx=%0d required gnt=0001 idx=0",
                     gnt, gnt_idx);
        end
    endtask

    task automatic test_single_request();
        apply_reset();
        for (int c = 1; c <= 5; c++) begin
            tick(4'b0100);
            checks++;
            if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || {gnt, gnt_idx, gnt_valid, preempt} !== exp_vec()) begin
                failures++;
                $display("FAIL single_hold c%0d: got gnt=%b idx=%0d required gnt=0100 idx=2",
                         c, gnt, gnt_idx);
            end
        end
        tick(4'b0000);
        checks++;
        if ({gnt, gnt_idx, gnt_valid} !== 7'h00) begin
            failures++;
            $display("FAIL single_release: got %b required 0000000", {gnt, gnt_idx, gnt_valid});
        end
        // ptr is now 3: all four requesting must pick index 3.
        tick(4'b1111);
        checks++;
        if (gnt_idx !== 2'd3 || gnt !== 4'b1000) begin
            failures++;
            $display("FAIL single_ptr: got idx=%0d required 3", gnt_idx);
        end
    endtask

    task automatic test_rotation();
        int order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        for (int n = 0; n < 5; n++) begin
            tick(4'b1111);
            checks++;
            if (gnt_idx !== 2'(order[n]) || gnt !== (4'b0001 << order[n]) || gnt_valid !== 1'b1) begin
                failures++;
                $display("FAIL rotation_grant n%0d: got idx=%0d gnt=%b required idx=%0d",
                         n, gnt_idx, gnt, order[n]);
            end
            tick(4'b1111);
            tick(4'b1111);
            tick(4'b1111 & ~(4'b0001 << order[n]));
            checks++;
            if (gnt_valid !== 1'b0 || gnt !== 4'b0000) begin
                failures++;
                $display("FAIL rotation_idle n%0d: got valid=%b gnt=%b required 0 0000",
                         n, gnt_valid, gnt);
            end
        end
    endtask

    task automatic test_hold_stability();
        logic [3:0] others;
        apply_reset();
        tick(4'b0001);
        tick(4'b0000);
        tick(4'b0010);
        others = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            others = ~others & 4'b1101;
            tick(others | 4'b0010);
            checks++;
            if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || {gnt, gnt_idx, gnt_valid, preempt} !== exp_vec()) begin
                failures++;
                $display("FAIL hold_stable c%0d: got gnt=%b idx=%0d required gnt=0010 idx=1",
                         c, gnt, gnt_idx);
            end
        end
        tick(4'b1101);
        checks++;
        if (gnt !== 4'b0000) begin
            failures++;
            $display("FAIL hold_release: got gnt=%b required 0000", gnt);
        end
    endtask

    task automatic test_wrap_skip();
        apply_reset();
        tick(4'b0100);
        tick(4'b0000);
        tick(4'b0011);
        checks++;
        if (gnt_idx !== 2'd0 || gnt !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_grant: got idx=%0d gnt=%b required idx=0", gnt_idx, gnt);
        end
        tick(4'b0010);
        tick(4'b0011);
        checks++;
        if (gnt_idx !== 2'd1 || gnt !== 4'b0010) begin
            failures++;
            $display("FAIL skip_grant: got idx=%0d gnt=%b required idx=1", gnt_idx, gnt);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int c = 1; c <= 10; c++) begin
            tick(4'b0101);
            checks++;
            if ({gnt, gnt_idx, gnt_valid, preempt} !== exp_vec()) begin
                failures++;
                $display("FAIL timeout_compete c%0d: got %b required %b", c,
                         {gnt, gnt_idx, gnt_valid, preempt}, exp_vec());
            end
`ifdef ARB_TIMEOUT_EN
            if (c == 9) begin
                checks++;
                if (preempt !== 1'b1 || gnt !== 4'b0000) begin
                    failures++;
                    $display("FAIL timeout_preempt: got preempt=%b gnt=%b required 1 0000",
                             preempt, gnt);
                end
            end
            if (c == 10) begin
                checks++;
                if (gnt_idx !== 2'd2 || preempt !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_next: got idx=%0d preempt=%b required 2 0",
                             gnt_idx, preempt);
                end
            end
`else
            checks++;
            if (gnt !== 4'b0001 || preempt !== 1'b0) begin
                failures++;
                $display("FAIL no_timeout c%0d: got gnt=%b preempt=%b required 0001 0",
                         c, gnt, preempt);
            end
`endif
        end
        // Lone owner: never preempted.
        apply_reset();
        for (int c = 1; c <= 14; c++) begin
            tick(4'b0001);
            checks++;
            if (gnt !== 4'b0001 || preempt !== 1'b0) begin
                failures++;
                $display("FAIL lone_owner c%0d: got gnt=%b preempt=%b required 0001 0",
                         c, gnt, preempt);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            r = 4'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
            tick(r);
            checks++;
            if ({gnt, gnt_idx, gnt_valid, preempt} !== exp_vec()) begin
                failures++;
                $display("FAIL random c%0d req=%b: got %b required %b", c, r,
                         {gnt, gnt_idx, gnt_valid, preempt}, exp_vec());
            end
            checks++;
            if (!$onehot0(gnt) || gnt_valid !== (|gnt) ||
                (gnt_valid && gnt !== (4'b0001 << gnt_idx)) || (!gnt_valid && gnt_idx !== 2'd0)) begin
                failures++;
                $display("FAIL invariant c%0d: got gnt=%b idx=%0d valid=%b", c, gnt, gnt_idx,
                         gnt_valid);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        model_reset();
        #12;
        rst = 1'b0;
        test_reset();
        test_single_request();
        test_rotation();
        test_hold_stability();
        test_wrap_skip();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
